uart_resp_fmt: RTL and testbench
================================

# uart_resp_fmt

Response formatter between the debug command engine and the `uart_tx` serializer. It accepts one response request at a time with a kind and up to two 32-bit operands. It renders the request as an ASCII line: a prefix character, fixed-width hex fields, then CR LF. It feeds the line byte by byte to `uart_tx`, and replaces the ad-hoc `send_*` flag and `tx_cnt` sequencing inside the debug block.

## Interface
- `HEX_UPPER`, default 1: 1 emits hex digits A–F; 0 emits a–f.
- `clk_i`  in  1  system clock, 100 MHz.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `req_valid_i`  in  1  response request valid.
- `req_ready_o`  out  1  formatter idle; the request is taken when valid & ready.
- `req_kind_i`  in  2  0=STATUS, 1=READ, 2=WRITE, 3=TIME.
- `req_a_i`  in  32  first operand (status word / read data / write addr / time value).
- `req_b_i`  in  32  second operand (write data; ignored for other kinds).
- `tx_stb_o`  out  1  one-cycle byte strobe to `uart_tx`.
- `tx_data_o`  out  8  byte accompanying `tx_stb_o`.
- `tx_busy_i`  in  1  serializer busy.
- `busy_o`  out  1  line in progress (inverse of `req_ready_o`).

## Operation
- Line formats, most significant nibble first:
  - STATUS: `S`, hex(a), CR, LF. 11 bytes.
  - READ: `R`, hex(a), CR, LF. 11 bytes.
  - TIME: `T`, hex(a), CR, LF. 11 bytes.
  - WRITE: `W`, hex(a), space, hex(b), CR, LF. 20 bytes.
- On accept, operands and kind are latched. Inputs may change afterwards without effect.
- FSM states:
  - IDLE: ready=1. On accept, go to EMIT with index=0.
  - EMIT: when `tx_busy_i`=0, pulse `tx_stb_o` with byte[index], then go to GUARD.
  - GUARD: exactly one cycle; `tx_busy_i` is ignored. If index = last, go to IDLE; else increment index and go to EMIT.
- Index: 5-bit counter, 0..19. Last index is 10 for 11-byte lines and 19 for WRITE.
- Byte selection: nibble = latched word >> (4×(7−k)). ASCII for 0–9 is 0x30+n; for 10–15 it is 0x41+n−10 when HEX_UPPER=1, else 0x61+n−10.
- `tx_data_o` holds its last value between strobes.

## Timing
- Reset values: `tx_stb_o`=0, `tx_data_o`=0x00, state IDLE, `req_ready_o`=1, `busy_o`=0, index=0.
- Accept in cycle N with `tx_busy_i` low gives the first strobe in cycle N+1.
- Minimum strobe spacing is 2 cycles (GUARD). Steady state is paced by the `tx_busy_i` fall.
- `uart_tx` raises busy no later than 1 cycle after the strobe. GUARD covers that window.
- `tx_busy_i` high while in EMIT: stall, no strobe, byte index held.
- `req_valid_i` while busy: not accepted; ready stays 0. The request is accepted in the first IDLE cycle.
- Back-to-back requests: the earliest accept is the cycle after the final GUARD. The gap between lines is ≥1 cycle.
- Reset mid-line: the line is abandoned immediately. No further strobes, and no truncation recovery; the host resyncs on CR LF.
- Unknown kind cannot occur (2-bit, fully decoded).

## Structure
- Package `uart_dbg_pkg` holds:
  - `resp_kind_e` enum (STATUS/READ/WRITE/TIME);
  - ASCII constants `ASCII_CR`=0x0D, `ASCII_LF`=0x0A, `ASCII_SP`=0x20;
  - prefix characters;
  - function `hex_nib2ascii(nib, upper)`.
- The debug command engine imports the same package.
- Single module; no sub-module. The nibble-to-ASCII conversion is the package function, and the byte select is a combinational mux on index and kind.

## Test plan
- STATUS, a=0xDEADBEEF, `tx_busy_i` modeled by `uart_tx` at 115200 → monitor reads `SDEADBEEF\r\n`, 11 strobes; `req_ready_o` returns to 1 after the last GUARD.
- WRITE, a=0x12345678, b=0x89ABCDEF → `W12345678 89ABCDEF\r\n`, 20 bytes; with HEX_UPPER=0 the second field is `89abcdef`.
- READ a=0xAAAAAAAA, then TIME a=0x00000000 held valid during the first line → second request accepted only after `RAAAAAAAA\r\n` completes, then `T00000000\r\n`; no interleaving.
- Force `tx_busy_i`=0 permanently → strobes every 2 cycles, first strobe in the cycle after accept; `tx_data_o` sequence exact.
- Assert `rst_i` asynchronously after the 5th byte of a WRITE → `tx_stb_o` low within the same cycle, `req_ready_o`=1 after release, and the next STATUS line emits correctly from `S`.
- Hold `tx_busy_i` high 100 cycles in EMIT → no strobe, index frozen; release → correct next byte, no duplicate or skip.

Source files
------------

// File: rtl/uart_dbg_pkg.sv
// Shared definitions for the debug UART path: response kinds, ASCII constants,
// line prefixes and hex-digit rendering helpers.
package uart_dbg_pkg;

    typedef enum logic [1:0] {
        RESP_STATUS = 2'd0,
        RESP_READ   = 2'd1,
        RESP_WRITE  = 2'd2,
        RESP_TIME   = 2'd3
    } resp_kind_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_SP = 8'h20;

    localparam logic [7:0] PFX_STATUS = 8'h53;  // 'S'
    localparam logic [7:0] PFX_READ   = 8'h52;  // 'R'
    localparam logic [7:0] PFX_WRITE  = 8'h57;  // 'W'
    localparam logic [7:0] PFX_TIME   = 8'h54;  // 'T'

    localparam logic [4:0] LAST_IDX_SHORT = 5'd10;
    localparam logic [4:0] LAST_IDX_WRITE = 5'd19;

    function automatic logic [7:0] hex_nib2ascii(input logic [3:0] nib, input logic upper);
        logic [7:0] chr;
        if (nib < 4'd10) begin
            chr = 8'h30 + {4'h0, nib};
        end else if (upper) begin
            chr = 8'h41 + {4'h0, nib} - 8'd10;
        end else begin
            chr = 8'h61 + {4'h0, nib} - 8'd10;
        end
        return chr;
    endfunction

    function automatic logic [7:0] kind_prefix(input resp_kind_e kind);
        logic [7:0] pfx;
        case (kind)
            RESP_STATUS: pfx = PFX_STATUS;
            RESP_READ:   pfx = PFX_READ;
            RESP_WRITE:  pfx = PFX_WRITE;
            RESP_TIME:   pfx = PFX_TIME;
            default:     pfx = PFX_STATUS;
        endcase
        return pfx;
    endfunction

    function automatic logic [4:0] last_index(input resp_kind_e kind);
        logic [4:0] last;
        if (kind == RESP_WRITE) begin
            last = LAST_IDX_WRITE;
        end else begin
            last = LAST_IDX_SHORT;
        end
        return last;
    endfunction

    // Nibble k of a word, k=0 being the most significant.
    function automatic logic [3:0] word_nibble(input logic [31:0] word, input logic [2:0] k);
        logic [31:0] shifted;
        shifted = word >> {3'd7 - k, 2'b00};
        return shifted[3:0];
    endfunction

endpackage

// File: rtl/uart_resp_fmt.sv
// Renders one debug response as an ASCII line (prefix, hex fields, CR LF) and
// paces it byte by byte into uart_tx with a one-cycle guard after each strobe.
module uart_resp_fmt
    import uart_dbg_pkg::*;
#(
    parameter bit HEX_UPPER = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_kind_i,
    input  logic [31:0] req_a_i,
    input  logic [31:0] req_b_i,
    output logic        tx_stb_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_busy_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EMIT  = 2'd1,
        ST_GUARD = 2'd2
    } fmt_state_e;

    fmt_state_e  state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    resp_kind_e  kind_q, kind_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [7:0]  data_q, data_d;

    logic [7:0]  cur_byte_s;
    logic [2:0]  a_nib_k_s;
    logic [2:0]  b_nib_k_s;
    logic        stb_s;

    assign a_nib_k_s = 3'(idx_q - 5'd1);
    assign b_nib_k_s = 3'(idx_q - 5'd10);

    // Byte select: combinational mux on the latched kind and the byte index.
    always_comb begin
        cur_byte_s = 8'h00;
        if (idx_q == 5'd0) begin
            cur_byte_s = kind_prefix(kind_q);
        end else if (idx_q <= 5'd8) begin
            cur_byte_s = hex_nib2ascii(word_nibble(a_q, a_nib_k_s), HEX_UPPER);
        end else if (kind_q != RESP_WRITE) begin
            if (idx_q == 5'd9) begin
                cur_byte_s = ASCII_CR;
            end else begin
                cur_byte_s = ASCII_LF;
            end
        end else begin
            if (idx_q == 5'd9) begin
                cur_byte_s = ASCII_SP;
            end else if (idx_q <= 5'd17) begin
                cur_byte_s = hex_nib2ascii(word_nibble(b_q, b_nib_k_s), HEX_UPPER);
            end else if (idx_q == 5'd18) begin
                cur_byte_s = ASCII_CR;
            end else begin
                cur_byte_s = ASCII_LF;
            end
        end
    end

    // Next-state logic: accept, emit-on-not-busy, single-cycle guard.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        kind_d  = kind_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        stb_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    kind_d  = resp_kind_e'(req_kind_i);
                    a_d     = req_a_i;
                    b_d     = req_b_i;
                    idx_d   = 5'd0;
                    state_d = ST_EMIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (!tx_busy_i) begin
                    stb_s   = 1'b1;
                    data_d  = cur_byte_s;
                    state_d = ST_GUARD;
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_GUARD: begin
                // Serializer busy may still be low here, so it is not sampled.
                if (idx_q == last_index(kind_q)) begin
                    idx_d   = 5'd0;
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + 5'd1;
                    state_d = ST_EMIT;
                end
            end
            default: begin
                idx_d   = 5'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, operand and held-byte registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= 5'd0;
            kind_q  <= RESP_STATUS;
            a_q     <= 32'h0000_0000;
            b_q     <= 32'h0000_0000;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            kind_q  <= kind_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
        end
    end

    // The strobe fires in the EMIT cycle itself so the first byte follows the accept directly.
    assign tx_stb_o    = stb_s;
    assign tx_data_o   = stb_s ? cur_byte_s : data_q;
    assign req_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_resp_fmt.sv
// Randomized bench for uart_resp_fmt: a string-based line model, a uart_tx busy
// model and per-scenario tasks with inline comparisons.
module tb_uart_resp_fmt;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic [1:0]  req_kind_i = 2'd0;
    logic [31:0] req_a_i = 32'h0;
    logic [31:0] req_b_i = 32'h0;
    logic        tx_busy_i = 1'b0;

    logic        req_ready_o, tx_stb_o, busy_o;
    logic [7:0]  tx_data_o;
    logic        req_ready_lc, tx_stb_lc, busy_lc;
    logic [7:0]  tx_data_lc;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int busy_mode = 0;   // 0: never busy, 1: uart_tx-like, 2: held busy
    int busy_cnt  = 0;

    bq_t rx_q;
    bq_t rx_lc_q;
    int  stb_cyc_q[$];

    uart_resp_fmt #(.HEX_UPPER(1'b1)) u_dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_kind_i(req_kind_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
        .tx_stb_o(tx_stb_o), .tx_data_o(tx_data_o),
        .tx_busy_i(tx_busy_i), .busy_o(busy_o)
    );

    uart_resp_fmt #(.HEX_UPPER(1'b0)) u_dut_lc (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_lc),
        .req_kind_i(req_kind_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
        .tx_stb_o(tx_stb_lc), .tx_data_o(tx_data_lc),
        .tx_busy_i(tx_busy_i), .busy_o(busy_lc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte monitor on the falling edge.
    always @(negedge clk) begin
        if (tx_stb_o) begin
            rx_q.push_back(tx_data_o);
            stb_cyc_q.push_back(cyc);
        end
        if (tx_stb_lc) rx_lc_q.push_back(tx_data_lc);
    end

    // uart_tx busy model: busy rises the cycle after a strobe, lasts a random time.
    always @(posedge clk) begin
        case (busy_mode)
            0: begin tx_busy_i <= 1'b0; busy_cnt <= 0; end
            2: begin tx_busy_i <= 1'b1; busy_cnt <= 0; end
            default: begin
                if (tx_stb_o) begin
                    busy_cnt  <= $urandom_range(2, 12);
                    tx_busy_i <= 1'b1;
                end else if (busy_cnt > 1) begin
                    busy_cnt  <= busy_cnt - 1;
                    tx_busy_i <= 1'b1;
                end else begin
                    busy_cnt  <= 0;
                    tx_busy_i <= 1'b0;
                end
            end
        endcase
    end

    function automatic bq_t exp_line(input logic [1:0] k, input logic [31:0] a,
                                     input logic [31:0] b, input bit upper);
        bq_t q;
        string s, h;
        case (k)
            2'd0: s = "S";
            2'd1: s = "R";
            2'd2: s = "W";
            default: s = "T";
        endcase
        h = $sformatf("%08x", a);
        if (upper) h = h.toupper();
        s = {s, h};
        if (k == 2'd2) begin
            h = $sformatf("%08x", b);
            if (upper) h = h.toupper();
            s = {s, " ", h};
        end
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        q.push_back(8'h0D);
        q.push_back(8'h0A);
        return q;
    endfunction

    function automatic int first_diff(input bq_t g, input bq_t e);
        int n;
        n = (g.size() < e.size()) ? g.size() : e.size();
        for (int i = 0; i < n; i++) if (g[i] !== e[i]) return i;
        if (g.size() != e.size()) return n;
        return -1;
    endfunction

    function automatic string hexs(input bq_t q);
        string s;
        s = "";
        foreach (q[i]) s = {s, $sformatf("%02h", q[i])};
        return s;
    endfunction

    task automatic clear_mon();
        rx_q.delete();
        rx_lc_q.delete();
        stb_cyc_q.delete();
    endtask

    task automatic send(input logic [1:0] k, input logic [31:0] a, input logic [31:0] b,
                        output int acc);
        int t;
        t = 0;
        @(negedge clk);
        req_valid_i = 1'b1; req_kind_i = k; req_a_i = a; req_b_i = b;
        while (req_ready_o !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        n_tests++;
        if (t >= 5000) begin
            $display("FAIL send_accept: ready=%b after %0d cycles, required 1", req_ready_o, t);
            n_fail++;
        end
        acc = cyc;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        req_kind_i = 2'($urandom);
        req_a_i = $urandom;
        req_b_i = $urandom;
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit ok);
        int t;
        t = 0;
        ok = 1'b1;
        while (rx_q.size() < n) begin
            if (t >= budget) begin ok = 1'b0; break; end
            @(negedge clk); #1;
            t++;
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if ({req_ready_o, busy_o, tx_stb_o, tx_data_o} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            $display("FAIL reset_outputs: ready/busy/stb/data=%b/%b/%b/%h, required 1/0/0/00",
                     req_ready_o, busy_o, tx_stb_o, tx_data_o);
            n_fail++;
        end
    endtask

    task automatic test_status();
        int acc; bit ok; bq_t e;
        busy_mode = 1;
        clear_mon();
        send(2'd0, 32'hDEADBEEF, $urandom, acc);
        wait_bytes(11, 3000, ok);
        n_tests++;
        if (ok !== 1'b1) begin $display("FAIL status_timeout: got %0d bytes, required 11", rx_q.size()); n_fail++; end
        @(negedge clk); #1;
        n_tests++;
        if (req_ready_o !== 1'b0) begin $display("FAIL status_guard_ready: got %b, required 0", req_ready_o); n_fail++; end
        @(negedge clk); #1;
        n_tests++;
        if ({req_ready_o, busy_o} !== 2'b10) begin
            $display("FAIL status_ready_back: ready/busy=%b/%b, required 1/0", req_ready_o, busy_o); n_fail++;
        end
        repeat (20) @(negedge clk);
        e = exp_line(2'd0, 32'hDEADBEEF, 32'h0, 1'b1);
        n_tests++;
        if (first_diff(rx_q, e) != -1) begin
            $display("FAIL status_line: got %s, required %s", hexs(rx_q), hexs(e)); n_fail++;
        end
    endtask

    task automatic test_write();
        int acc; bit ok; bq_t e, el;
        busy_mode = 1;
        clear_mon();
        send(2'd2, 32'h12345678, 32'h89ABCDEF, acc);
        wait_bytes(20, 6000, ok);
        repeat (20) @(negedge clk);
        e  = exp_line(2'd2, 32'h12345678, 32'h89ABCDEF, 1'b1);
        el = exp_line(2'd2, 32'h12345678, 32'h89ABCDEF, 1'b0);
        n_tests++;
        if (first_diff(rx_q, e) != -1) begin
            $display("FAIL write_line_upper: got %s, required %s", hexs(rx_q), hexs(e)); n_fail++;
        end
        n_tests++;
        if (first_diff(rx_lc_q, el) != -1) begin
            $display("FAIL write_line_lower: got %s, required %s", hexs(rx_lc_q), hexs(el)); n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        int acc, t; bit ok; bq_t e, e2;
        busy_mode = 1;
        clear_mon();
        send(2'd1, 32'hAAAAAAAA, $urandom, acc);
        req_valid_i = 1'b1; req_kind_i = 2'd3; req_a_i = 32'h0; req_b_i = $urandom;
        t = 0;
        while (t < 5000) begin
            @(negedge clk); #1;
            t++;
            if (req_ready_o === 1'b1) break;
        end
        n_tests++;
        if (rx_q.size() !== 11) begin
            $display("FAIL b2b_early_accept: bytes before second accept %0d, required 11", rx_q.size()); n_fail++;
        end
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        wait_bytes(22, 6000, ok);
        repeat (20) @(negedge clk);
        e  = exp_line(2'd1, 32'hAAAAAAAA, 32'h0, 1'b1);
        e2 = exp_line(2'd3, 32'h00000000, 32'h0, 1'b1);
        foreach (e2[i]) e.push_back(e2[i]);
        n_tests++;
        if (first_diff(rx_q, e) != -1) begin
            $display("FAIL b2b_lines: got %s, required %s", hexs(rx_q), hexs(e)); n_fail++;
        end
    endtask

    task automatic test_no_busy();
        int acc, bad; bit ok; bq_t e;
        logic [1:0] k; logic [31:0] a, b;
        busy_mode = 0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            k = (i < 4) ? 2'(i) : 2'($urandom_range(0, 3));
            a = $urandom; b = $urandom;
            e = exp_line(k, a, b, 1'b1);
            clear_mon();
            send(k, a, b, acc);
            wait_bytes(e.size(), 200, ok);
            repeat (4) @(negedge clk);
            n_tests++;
            if (stb_cyc_q.size() == 0 || stb_cyc_q[0] !== acc + 1) begin
                $display("FAIL nobusy_first_strobe[%0d]: got cycle %0d, required %0d", i,
                         (stb_cyc_q.size() == 0) ? -1 : stb_cyc_q[0], acc + 1);
                n_fail++;
            end
            bad = 0;
            for (int j = 1; j < stb_cyc_q.size(); j++) if (stb_cyc_q[j] - stb_cyc_q[j-1] != 2) bad++;
            n_tests++;
            if (bad !== 0) begin
                $display("FAIL nobusy_spacing[%0d]: got %0d gaps not equal to 2, required 0", i, bad); n_fail++;
            end
            n_tests++;
            if (first_diff(rx_q, e) != -1) begin
                $display("FAIL nobusy_line[%0d]: got %s, required %s", i, hexs(rx_q), hexs(e)); n_fail++;
            end
        end
    endtask

    task automatic test_stall();
        int acc, rel; bit ok; bq_t e; logic [31:0] a;
        busy_mode = 0;
        a = $urandom;
        e = exp_line(2'd1, a, 32'h0, 1'b1);
        clear_mon();
        send(2'd1, a, $urandom, acc);
        wait_bytes(3, 200, ok);
        busy_mode = 2;
        repeat (100) @(negedge clk);
        #1;
        n_tests++;
        if (rx_q.size() !== 3 || req_ready_o !== 1'b0) begin
            $display("FAIL stall_hold: got %0d bytes ready=%b, required 3 bytes ready=0", rx_q.size(), req_ready_o);
            n_fail++;
        end
        rel = cyc;
        busy_mode = 0;
        wait_bytes(11, 200, ok);
        repeat (4) @(negedge clk);
        n_tests++;
        if (stb_cyc_q.size() < 4 || stb_cyc_q[3] !== rel + 1) begin
            $display("FAIL stall_release_strobe: got cycle %0d, required %0d",
                     (stb_cyc_q.size() < 4) ? -1 : stb_cyc_q[3], rel + 1);
            n_fail++;
        end
        n_tests++;
        if (first_diff(rx_q, e) != -1) begin
            $display("FAIL stall_line: got %s, required %s", hexs(rx_q), hexs(e)); n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        int acc; bit ok; bq_t e; logic [31:0] a;
        busy_mode = 0;
        clear_mon();
        send(2'd2, $urandom, $urandom, acc);
        wait_bytes(5, 200, ok);
        rst_i = 1'b1;
        #1;
        n_tests++;
        if ({tx_stb_o, req_ready_o, busy_o, tx_data_o} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
            $display("FAIL midreset_outputs: stb/ready/busy/data=%b/%b/%b/%h, required 0/1/0/00",
                     tx_stb_o, req_ready_o, busy_o, tx_data_o);
            n_fail++;
        end
        @(negedge clk);
        rst_i = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        n_tests++;
        if (rx_q.size() !== 5 || req_ready_o !== 1'b1) begin
            $display("FAIL midreset_abandon: got %0d bytes ready=%b, required 5 bytes ready=1", rx_q.size(), req_ready_o);
            n_fail++;
        end
        a = $urandom;
        e = exp_line(2'd0, a, 32'h0, 1'b1);
        clear_mon();
        send(2'd0, a, $urandom, acc);
        wait_bytes(11, 200, ok);
        repeat (4) @(negedge clk);
        n_tests++;
        if (first_diff(rx_q, e) != -1) begin
            $display("FAIL midreset_next_line: got %s, required %s", hexs(rx_q), hexs(e)); n_fail++;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        test_reset();
        rst_i = 1'b0;
        @(negedge clk); #1;
        test_reset();
        test_status();
        test_write();
        test_back_to_back();
        test_no_busy();
        test_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
